// File: rtl/rv32_muldiv_pkg.sv
// Shared rv32 definitions: base opcode constants, M-extension funct3 encodings
// and the multiply/divide unit state encoding.
package rv32_muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // rs1 is signed for MULH, MULHSU, DIV and REM
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
  endfunction

endpackage

// File: rtl/rv32_muldiv_if.sv
// Request/result bundle between the execute pipeline and the multiply/divide unit.
interface rv32_muldiv_if;
  import rv32_muldiv_pkg::*;

  logic            stall_in;
  logic            flush_in;
  logic            valid_in;
  logic [2:0]      op_in;
  logic [XLEN-1:0] rs1_value_in;
  logic [XLEN-1:0] rs2_value_in;
  logic            busy_out;
  logic            valid_out;
  logic [XLEN-1:0] rd_value_out;

  modport master (
    output stall_in, flush_in, valid_in, op_in, rs1_value_in, rs2_value_in,
    input  busy_out, valid_out, rd_value_out
  );

  modport slave (
    input  stall_in, flush_in, valid_in, op_in, rs1_value_in, rs2_value_in,
    output busy_out, valid_out, rd_value_out
  );
endinterface

// File: rtl/rv32_muldiv_sign.sv
// Combinational sign handling: operand magnitudes on entry, result negation on exit.
module rv32_muldiv_sign (
  input  logic [1:0][31:0] opnd,
  input  logic [1:0]       opnd_signed,
  output logic [1:0]       opnd_neg,
  output logic [1:0][31:0] opnd_abs,
  input  logic [63:0]      res,
  input  logic             res_neg,
  output logic [63:0]      res_fixed
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_abs
    assign opnd_neg[gi] = opnd_signed[gi] & opnd[gi][31];
    assign opnd_abs[gi] = opnd_neg[gi] ? (~opnd[gi] + 32'd1) : opnd[gi];
  end

  assign res_fixed = res_neg ? (~res + 64'd1) : res;

endmodule

// File: rtl/rv32_muldiv.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on magnitudes,
// with divide-by-zero and signed overflow answered immediately.
module rv32_muldiv
  import rv32_muldiv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  rv32_muldiv_if.slave  bus
);

  muldiv_state_e state_reg;
  logic [63:0]   acc_reg;
  logic [31:0]   b_reg;
  logic [4:0]    count_reg;
  logic          neg_reg;
  logic [2:0]    op_reg;
  logic          valid_reg;
  logic [31:0]   rd_reg;

  logic [1:0]       in_neg;
  logic [1:0][31:0] in_abs;
  logic [63:0]      res_raw;
  logic [63:0]      res_fixed;

  rv32_muldiv_sign u_sign (
    .opnd        ({bus.rs2_value_in, bus.rs1_value_in}),
    .opnd_signed ({op_b_signed(bus.op_in), op_a_signed(bus.op_in)}),
    .opnd_neg    (in_neg),
    .opnd_abs    (in_abs),
    .res         (res_raw),
    .res_neg     (neg_reg),
    .res_fixed   (res_fixed)
  );

  // Accept-time decode of the sign and special cases
  logic        in_div;
  logic        in_rem;
  logic        in_neg_res;
  logic        in_div_zero;
  logic        in_overflow;
  logic [31:0] in_special_val;

  always_comb begin
    in_div      = op_is_div(bus.op_in);
    in_rem      = op_is_rem(bus.op_in);
    in_neg_res  = in_rem ? in_neg[0] : (in_neg[0] ^ in_neg[1]);
    in_div_zero = in_div && (bus.rs2_value_in == 32'd0);
    in_overflow = in_div && !bus.op_in[0] &&
                  (bus.rs1_value_in == 32'h8000_0000) && (bus.rs2_value_in == 32'hFFFF_FFFF);
    in_special_val = 32'd0;
    if (in_div_zero) begin
      in_special_val = in_rem ? bus.rs1_value_in : 32'hFFFF_FFFF;
    end else if (in_overflow) begin
      in_special_val = in_rem ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration: acc holds {partial_hi, multiplier} or {remainder, dividend/quotient}
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_shift;
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] step_next;
  logic [31:0] final_val;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, b_reg} : 33'd0);
    mul_next  = {mul_sum, acc_reg[31:1]};
    rem_shift = acc_reg[63:31];
    div_diff  = {1'b0, rem_shift} - {2'b00, b_reg};
    div_next  = div_diff[33] ? {rem_shift[31:0], acc_reg[30:0], 1'b0}
                             : {div_diff[31:0], acc_reg[30:0], 1'b1};
    step_next = op_is_div(op_reg) ? div_next : mul_next;

    if (!op_is_div(op_reg)) begin
      res_raw = step_next;
    end else if (op_is_rem(op_reg)) begin
      res_raw = {32'd0, step_next[63:32]};
    end else begin
      res_raw = {32'd0, step_next[31:0]};
    end

    final_val = ((op_reg == F3_MUL) || op_is_div(op_reg)) ? res_fixed[31:0] : res_fixed[63:32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      acc_reg   <= 64'd0;
      b_reg     <= 32'd0;
      count_reg <= 5'd0;
      neg_reg   <= 1'b0;
      op_reg    <= F3_MUL;
      valid_reg <= 1'b0;
      rd_reg    <= 32'd0;
    end else if (bus.flush_in) begin
      state_reg <= ST_IDLE;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.valid_in) begin
            if (in_div_zero || in_overflow) begin
              rd_reg    <= in_special_val;
              valid_reg <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              acc_reg   <= {32'd0, in_abs[0]};
              b_reg     <= in_abs[1];
              neg_reg   <= in_neg_res;
              op_reg    <= bus.op_in;
              count_reg <= 5'd31;
              state_reg <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          acc_reg <= step_next;
          if (count_reg == 5'd0) begin
            rd_reg    <= final_val;
            valid_reg <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            count_reg <= count_reg - 5'd1;
          end
        end
        ST_DONE: begin
          if (!bus.stall_in) begin
            valid_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_out     = (state_reg != ST_IDLE);
  assign bus.valid_out    = valid_reg;
  assign bus.rd_value_out = rd_reg;

endmodule

// File: tb/tb_rv32_muldiv.sv
// Randomized and directed bench for rv32_muldiv against a 64-bit arithmetic model.
module tb_rv32_muldiv;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32_muldiv_if bus();

  rv32_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Present one op, count edges from the accepting edge until valid_out, check value/latency/width
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] exp;
    exp = model(op, a, b);
    lat = 0;
    @(negedge clk);
    bus.valid_in     = 1'b1;
    bus.op_in        = op;
    bus.rs1_value_in = a;
    bus.rs2_value_in = b;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        bus.valid_in = 1'b0;
        bus.rs1_value_in = $urandom;
        bus.rs2_value_in = $urandom;
      end
      if (bus.valid_out) begin
        lat = n;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), is_special(op, a, b) ? 32'd1 : 32'd33);
    check({tag, " value"}, bus.rd_value_out, exp);
    @(posedge clk);
    #1;
    check({tag, " pulse"}, {31'd0, bus.valid_out}, 32'd0);
    $display("op=%0d a=%h b=%h rd=%h exp=%h lat=%0d", op, a, b, bus.rd_value_out, exp, lat);
    last_rd = exp;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic seen_valid;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b1;
    bus.stall_in = 1'b0;
    bus.flush_in = 1'b0;
    bus.valid_in = 1'b0;
    bus.op_in = 3'd0;
    bus.rs1_value_in = 32'd0;
    bus.rs2_value_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", {31'd0, bus.valid_out}, 32'd0);
    check("reset rd", bus.rd_value_out, 32'd0);
    check("reset busy", {31'd0, bus.busy_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mul 7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2);
    run_op("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2);
    run_op("divu -7/2", 3'b101, 32'hFFFF_FFF9, 32'd2);
    run_op("divu 5/0", 3'b101, 32'd5, 32'd0);
    run_op("remu 5/0", 3'b111, 32'd5, 32'd0);
    run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = rand_operand();
      rb = rand_operand();
      run_op("random", rop, ra, rb);
    end

    // Flush on BUSY cycle 10, then a fresh MUL
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.op_in = 3'b000;
    bus.rs1_value_in = 32'h1234_5678;
    bus.rs2_value_in = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    check("flush busy before", {31'd0, bus.busy_out}, 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush_in = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_in = 1'b0;
    check("flush busy", {31'd0, bus.busy_out}, 32'd0);
    check("flush valid", {31'd0, bus.valid_out}, 32'd0);
    check("flush rd kept", bus.rd_value_out, last_rd);
    seen_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out || bus.busy_out) seen_valid = 1'b1;
    end
    check("flush no result", {31'd0, seen_valid}, 32'd0);
    $display("flush on busy cycle 10 done");
    run_op("mul 3x4", 3'b000, 32'd3, 32'd4);

    // Flush overrides valid_in in IDLE
    @(negedge clk);
    bus.flush_in = 1'b1;
    bus.valid_in = 1'b1;
    bus.op_in = 3'b000;
    @(posedge clk);
    #1;
    bus.flush_in = 1'b0;
    bus.valid_in = 1'b0;
    check("flush over valid", {31'd0, bus.busy_out}, 32'd0);
    $display("flush with valid_in done");

    // Stall holds DONE for 5 extra cycles
    ra = $urandom;
    rb = $urandom;
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.op_in = 3'b011;
    bus.rs1_value_in = ra;
    bus.rs2_value_in = rb;
    seen_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      if (bus.valid_out) begin
        seen_valid = 1'b1;
        break;
      end
    end
    check("stall reached done", {31'd0, seen_valid}, 32'd1);
    bus.stall_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check("stall valid held", {31'd0, bus.valid_out}, 32'd1);
      check("stall value held", bus.rd_value_out, model(3'b011, ra, rb));
    end
    bus.stall_in = 1'b0;
    @(posedge clk);
    #1;
    check("stall release", {31'd0, bus.valid_out}, 32'd0);
    $display("stall 5 cycles done rd=%h", bus.rd_value_out);

    // Reset mid-BUSY
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.op_in = 3'b100;
    bus.rs1_value_in = 32'd1000;
    bus.rs2_value_in = 32'd7;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset valid", {31'd0, bus.valid_out}, 32'd0);
    check("midreset rd", bus.rd_value_out, 32'd0);
    check("midreset busy", {31'd0, bus.busy_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    $display("reset mid-busy done");
    run_op("after reset", 3'b110, 32'hFFFF_FC18, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_muldiv.md
RV32_MULDIV -- requirements
Module: rv32_muldiv

Interface
REQ-001 Parameters: none; all widths fixed at XLEN=32.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall_in  input  1  pipeline stall; holds a completed result.
REQ-005 flush_in  input  1  abort the in-flight operation.
REQ-006 valid_in  input  1  start request, sampled only in IDLE.
REQ-007 op_in  input  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 rs1_value_in  input  32  operand A (multiplicand/dividend), from the register-read stage.
REQ-009 rs2_value_in  input  32  operand B (multiplier/divisor).
REQ-010 busy_out  output  1  high whenever state != IDLE; decoded from registered state.
REQ-011 valid_out  output  1  result valid, registered.
REQ-012 rd_value_out  output  32  result, registered.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-014 IDLE with valid_in=1 SHALL latch the operands and op and enter BUSY; the iteration counter is set to 31.
REQ-015 IDLE with a divide-by-zero or signed-overflow case SHALL bypass BUSY and enter DONE directly.
REQ-016 valid_in while not IDLE SHALL be ignored.
REQ-017 BUSY SHALL perform one radix-2 step per cycle (shift-add multiply, restoring divide) on operand magnitudes.
REQ-018 BUSY SHALL enter DONE after the step with counter=0, i.e. after 32 BUSY cycles.
REQ-019 Normal latency SHALL be 33 cycles from the accepting edge to valid_out=1.
REQ-020 Special-case latency SHALL be 1 cycle.
REQ-021 The sign of the result SHALL be applied in the final BUSY step.
REQ-022 The signed operand set SHALL be: MULH both operands; MULHSU rs1 only; DIV/REM both; all other ops unsigned.
REQ-023 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32] of the exact 64-bit product.
REQ-024 DIV/DIVU SHALL truncate toward zero; the REM sign SHALL follow the dividend.
REQ-025 A divisor of 0 SHALL return quotient 0xFFFFFFFF and remainder = rs1.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0.
REQ-027 DONE SHALL drive valid_out=1 with rd_value_out stable.
REQ-028 DONE with stall_in=0 SHALL return to IDLE on the next edge; with stall_in=1 it SHALL remain in DONE, holding its outputs.
REQ-029 valid_out SHALL pulse for exactly one cycle per unstalled completion.
REQ-030 flush_in=1 in any state SHALL force IDLE, valid_out=0 next edge; flush SHALL override stall_in and valid_in in the same cycle.
REQ-031 A new op SHALL be accepted in the first IDLE cycle after DONE or flush.
REQ-032 rd_value_out SHALL keep its last value outside DONE.

Reset
REQ-033 Reset SHALL force state=IDLE, valid_out=0, rd_value_out=0, counter=0, busy_out=0.
REQ-034 Reset SHALL have priority over flush_in, stall_in and valid_in.
REQ-035 Reset mid-operation SHALL discard the operation with no valid_out.

Structure
REQ-036 The funct3 op encodings and the FSM state enum SHALL live in the shared rv32 package/header, alongside the existing opcode constants.
REQ-037 Datapath registers SHALL be: 64-bit accumulator/remainder, 32-bit operand B, 5-bit counter, negate flag, op.
REQ-038 One sub-module, rv32_muldiv_sign, SHALL be natural: combinational operand absolute-value and result negate logic.
REQ-039 No other sub-modules SHALL be used.

Verification
REQ-040 MUL 7 x 0xFFFFFFFD (-3) -> rd_value_out 0xFFFFFFEB, valid_out high exactly 33 cycles after accept, one cycle wide.
REQ-041 0xFFFFFFFF x 0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
REQ-042 -7 / 2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF, DIVU 0x7FFFFFFC.
REQ-043 Special cases: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM -> 0; each 1-cycle latency.
REQ-044 flush_in on BUSY cycle 10 -> no valid_out, busy_out=0 next cycle; MUL 3x4 accepted next -> 12.
REQ-045 stall_in=1 for 5 cycles in DONE -> valid_out held 6 cycles with value constant; reset asserted mid-BUSY -> all outputs zero next cycle.
